// File: rtl/dw_dbp_apb_arb.sv
// rtl/dw_dbp_apb_arb.sv - two-requester debug APB arbiter with auth policy check
//
// Purpose: round-robin arbitration of the debug APB master port between
//   requester 0 (JTAG/DMI) and requester 1 (system debugger), APB SETUP/ACCESS
//   sequencing, and dbgen/niden policy enforcement at grant time.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dbg_apb_dbgen/_niden     invasive / non-invasive debug enables
//   rN_req/write/addr/wdata  requester N request (level, held until after ack)
//   rN_ack/rdata/err         requester N single-cycle completion
//   paddr/psel/penable/pwrite/pwdata/prdata/pready/pslverr  APB master
//   arb_busy, arb_owner      status: not idle, current/last granted requester
//
// Optional feature: define DW_DBP_APB_TIMEOUT_EN to bound the ACCESS phase to
//   TIMEOUT wait cycles, after which the access completes with err=1.

module dw_dbp_apb_arb #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_apb_dbgen,
  input  logic              dbg_apb_niden,
  input  logic              r0_req,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic              r0_ack,
  output logic [31:0]       r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_ack,
  output logic [31:0]       r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              arb_busy,
  output logic              arb_owner
);

  if (TIMEOUT < 1) begin : g_timeout_range_check
    $error("dw_dbp_apb_arb: TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, DENY} state_t;

  state_t            state;
  logic              last;

  // Grant decision for the current IDLE cycle.
  logic              grant_idx;
  logic              grant_write;
  logic [ADDR_W-1:0] grant_addr;
  logic [31:0]       grant_wdata;
  logic              grant_allow;

`ifdef DW_DBP_APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 256) ? 8 : 16;
  logic [CNT_W-1:0]  wait_cnt;
`endif

  always_comb begin
    grant_idx = 1'b0;
    if (r0_req && r1_req) begin
      grant_idx = ~last;
    end else if (r1_req) begin
      grant_idx = 1'b1;
    end
    grant_write = grant_idx ? r1_write : r0_write;
    grant_addr  = grant_idx ? r1_addr  : r0_addr;
    grant_wdata = grant_idx ? r1_wdata : r0_wdata;
    // Writes are invasive; reads only need non-invasive permission.
    grant_allow = grant_write ? dbg_apb_dbgen : (dbg_apb_niden | dbg_apb_dbgen);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      arb_owner <= 1'b0;
      arb_busy  <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      r0_ack    <= 1'b0;
      r0_rdata  <= '0;
      r0_err    <= 1'b0;
      r1_ack    <= 1'b0;
      r1_rdata  <= '0;
      r1_err    <= 1'b0;
`ifdef DW_DBP_APB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      // Responses are single-cycle; rdata/err are forced low outside ack.
      r0_ack   <= 1'b0;
      r0_rdata <= '0;
      r0_err   <= 1'b0;
      r1_ack   <= 1'b0;
      r1_rdata <= '0;
      r1_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            arb_owner <= grant_idx;
            last      <= grant_idx;
            arb_busy  <= 1'b1;
            if (grant_allow) begin
              // Address/direction/data are frozen here for the whole transfer.
              state  <= SETUP;
              psel   <= 1'b1;
              paddr  <= grant_addr;
              pwrite <= grant_write;
              pwdata <= grant_wdata;
            end else begin
              state <= DENY;
              if (grant_idx) begin
                r1_ack <= 1'b1;
                r1_err <= 1'b1;
              end else begin
                r0_ack <= 1'b1;
                r0_err <= 1'b1;
              end
            end
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef DW_DBP_APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        ACCESS: begin
          if (pready) begin
            state   <= RESP;
            psel    <= 1'b0;
            penable <= 1'b0;
            if (arb_owner) begin
              r1_ack   <= 1'b1;
              r1_rdata <= pwrite ? 32'h0 : prdata;
              r1_err   <= pslverr;
            end else begin
              r0_ack   <= 1'b1;
              r0_rdata <= pwrite ? 32'h0 : prdata;
              r0_err   <= pslverr;
            end
          end
`ifdef DW_DBP_APB_TIMEOUT_EN
          // This wait cycle is the TIMEOUT-th one: abandon the transfer.
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= RESP;
            psel    <= 1'b0;
            penable <= 1'b0;
            if (arb_owner) begin
              r1_ack <= 1'b1;
              r1_err <= 1'b1;
            end else begin
              r0_ack <= 1'b1;
              r0_err <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        RESP, DENY: begin
          state    <= IDLE;
          arb_busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          arb_busy <= 1'b0;
          psel     <= 1'b0;
          penable  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dw_dbp_apb_arb.sv
// tb/tb_dw_dbp_apb_arb.sv - self-checking bench for dw_dbp_apb_arb
module tb_dw_dbp_apb_arb;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dbgen = 1'b0, niden = 1'b0;
  logic        r0_req = 1'b0, r0_write = 1'b0, r1_req = 1'b0, r1_write = 1'b0;
  logic [15:0] r0_addr = '0, r1_addr = '0;
  logic [31:0] r0_wdata = '0, r1_wdata = '0;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [15:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic        arb_busy, arb_owner;

  int n_chk = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  dw_dbp_apb_arb #(.ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .dbg_apb_dbgen(dbgen), .dbg_apb_niden(niden),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .arb_busy(arb_busy), .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access, tracked by its age in
  // cycles since the grant and whether its response cycle has arrived.
  logic        m_active, m_done, m_allowed, m_owner, m_last, m_wr, m_err;
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  int          m_age, m_wait;

  wire m_win = (r0_req && r1_req) ? ~m_last : r1_req;
  wire m_wwr = m_win ? r1_write : r0_write;
  wire m_ok  = m_wwr ? dbgen : (dbgen | niden);

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0; m_done <= 1'b0; m_last <= 1'b1; m_owner <= 1'b0;
      m_allowed <= 1'b0; m_age <= 0; m_wait <= 0; m_err <= 1'b0; m_rdata <= '0;
    end else if (!m_active) begin
      if (r0_req || r1_req) begin
        m_active  <= 1'b1;
        m_age     <= 1;
        m_wait    <= 0;
        m_owner   <= m_win;
        m_last    <= m_win;
        m_wr      <= m_wwr;
        m_addr    <= m_win ? r1_addr : r0_addr;
        m_wdata   <= m_win ? r1_wdata : r0_wdata;
        m_allowed <= m_ok;
        m_done    <= !m_ok;
        m_rdata   <= '0;
        m_err     <= !m_ok;
      end
    end else if (m_done) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
    end else begin
      m_age <= m_age + 1;
      if (m_age >= 2) begin
        if (pready) begin
          m_done  <= 1'b1;
          m_rdata <= m_wr ? 32'h0 : prdata;
          m_err   <= pslverr;
        end
`ifdef DW_DBP_APB_TIMEOUT_EN
        else if (m_wait + 1 >= TO) begin
          m_done  <= 1'b1;
          m_rdata <= '0;
          m_err   <= 1'b1;
        end else begin
          m_wait <= m_wait + 1;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic e_psel, e_ack0, e_ack1;
      e_psel = m_active && m_allowed && !m_done;
      e_ack0 = m_active && m_done && !m_owner;
      e_ack1 = m_active && m_done && m_owner;
      chk("arb_busy", arb_busy, m_active);
      chk("arb_owner", arb_owner, m_owner);
      chk("psel", psel, e_psel);
      chk("penable", penable, e_psel && (m_age >= 2));
      chk("r0_ack", r0_ack, e_ack0);
      chk("r1_ack", r1_ack, e_ack1);
      chk("r0_rdata", r0_rdata, e_ack0 ? m_rdata : 32'h0);
      chk("r1_rdata", r1_rdata, e_ack1 ? m_rdata : 32'h0);
      chk("r0_err", r0_err, e_ack0 ? m_err : 1'b0);
      chk("r1_err", r1_err, e_ack1 ? m_err : 1'b0);
      if (e_psel) begin
        chk("paddr", paddr, m_addr);
        chk("pwrite", pwrite, m_wr);
        chk("pwdata", pwdata, m_wdata);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request; pready rises after 'delay' ACCESS cycles.
  task automatic run_access(input bit r, input bit wr, input logic [15:0] a,
                            input logic [31:0] wd, input int delay,
                            output int ack_t, output int psel_t, output int pen_n,
                            output logic [31:0] rd, output logic err,
                            output logic [31:0] pwd);
    ack_t = -1; psel_t = -1; pen_n = 0; rd = '0; err = 1'b0; pwd = '0;
    pready = 1'b0;
    if (r) begin
      r1_req = 1'b1; r1_write = wr; r1_addr = a; r1_wdata = wd;
    end else begin
      r0_req = 1'b1; r0_write = wr; r0_addr = a; r0_wdata = wd;
    end
    for (int t = 1; t <= 40 && ack_t < 0; t++) begin
      tick;
      if (psel && psel_t < 0) begin
        psel_t = t;
        pwd = pwdata;
      end
      if (penable) begin
        pen_n++;
        pready = (pen_n > delay);
      end else begin
        pready = 1'b0;
      end
      if (r ? r1_ack : r0_ack) begin
        ack_t = t;
        rd  = r ? r1_rdata : r0_rdata;
        err = r ? r1_err : r0_err;
        r0_req = 1'b0;
        r1_req = 1'b0;
      end
    end
    pready = 1'b0;
    r0_req = 1'b0;
    r1_req = 1'b0;
    chk("ack_within_budget", (ack_t > 0), 1'b1);
  endtask

  initial begin
    int ack_t, psel_t, pen_n, got, cnt;
    logic [31:0] rd, pwd;
    logic err;
    logic [3:0] order;

    tick;
    cmp_en = 1'b1;
    tick;
    chk("reset_psel", psel, 1'b0);
    chk("reset_busy", arb_busy, 1'b0);
    rst = 1'b0;

    // Read, niden only, pready immediately.
    niden = 1'b1; dbgen = 1'b0; prdata = 32'hDEADBEEF; pslverr = 1'b0;
    run_access(1'b0, 1'b0, 16'h0040, 32'h0, 0, ack_t, psel_t, pen_n, rd, err, pwd);
    chk("rd_psel_cycle", psel_t, 1);
    chk("rd_ack_cycle", ack_t, 3);
    chk("rd_pen_cycles", pen_n, 1);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    chk("rd_err", err, 1'b0);
    tick;

    // Write denied without dbgen, then allowed.
    run_access(1'b1, 1'b1, 16'h0010, 32'h12345678, 0, ack_t, psel_t, pen_n, rd, err, pwd);
    chk("deny_ack_cycle", ack_t, 1);
    chk("deny_err", err, 1'b1);
    chk("deny_rdata", rd, 32'h0);
    chk("deny_no_psel", (psel_t < 0), 1'b1);
    tick;
    dbgen = 1'b1;
    run_access(1'b1, 1'b1, 16'h0010, 32'h12345678, 0, ack_t, psel_t, pen_n, rd, err, pwd);
    chk("wr_pwdata", pwd, 32'h12345678);
    chk("wr_ack_cycle", ack_t, 3);
    chk("wr_err", err, 1'b0);
    chk("wr_rdata", rd, 32'h0);
    tick;

    // Read with wait states and slave error.
    dbgen = 1'b0; pslverr = 1'b1;
    run_access(1'b0, 1'b0, 16'h0123, 32'h0, 5, ack_t, psel_t, pen_n, rd, err, pwd);
    chk("ws_pen_cycles", pen_n, 6);
    chk("ws_ack_cycle", ack_t, 8);
    chk("ws_err", err, 1'b1);
    chk("ws_rdata", rd, 32'hDEADBEEF);
    pslverr = 1'b0;
    tick;

    // Both requesters held continuously from reset: round-robin 0,1,0,1.
    rst = 1'b1; pready = 1'b1;
    r0_req = 1'b1; r0_write = 1'b0; r0_addr = 16'h0100;
    r1_req = 1'b1; r1_write = 1'b0; r1_addr = 16'h0200;
    tick;
    rst = 1'b0;
    got = 0; order = '0;
    for (int t = 0; t < 60 && got < 4; t++) begin
      tick;
      if (r0_ack || r1_ack) begin
        order[got] = r1_ack;
        chk("rr_owner_at_ack", arb_owner, r1_ack);
        got++;
        if (got == 4) begin
          r0_req = 1'b0;
          r1_req = 1'b0;
        end
      end
    end
    r0_req = 1'b0; r1_req = 1'b0; pready = 1'b0;
    chk("rr_ack_count", got, 4);
    chk("rr_order", order, 4'b1010);
    tick;

    // Reset in the middle of ACCESS aborts the transfer silently.
    r0_req = 1'b1; r0_write = 1'b0; r0_addr = 16'h0777;
    cnt = 0;
    for (int t = 0; t < 10 && !penable; t++) tick;
    chk("abort_reached_access", penable, 1'b1);
    rst = 1'b1;
    tick;
    chk("abort_psel", psel, 1'b0);
    chk("abort_penable", penable, 1'b0);
    chk("abort_busy", arb_busy, 1'b0);
    chk("abort_no_ack", r0_ack, 1'b0);
    rst = 1'b0; r0_req = 1'b0;
    tick;
    run_access(1'b0, 1'b0, 16'h0040, 32'h0, 0, ack_t, psel_t, pen_n, rd, err, pwd);
    chk("post_abort_ack_cycle", ack_t, 3);
    chk("post_abort_rdata", rd, 32'hDEADBEEF);
    tick;

`ifdef DW_DBP_APB_TIMEOUT_EN
    run_access(1'b0, 1'b0, 16'h0055, 32'h0, 1000, ack_t, psel_t, pen_n, rd, err, pwd);
    chk("to_pen_cycles", pen_n, 4);
    chk("to_ack_cycle", ack_t, 6);
    chk("to_err", err, 1'b1);
    chk("to_rdata", rd, 32'h0);
    tick;
`endif

    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
